mux_stream_n: RTL and testbench

MUX_STREAM_N -- requirements
Module: mux_stream_n

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter_n.sv | 34 +++
 rtl/mux_stream_n.sv | 119 +++++++++++
 tb/tb_mux_stream_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the streaming N-to-1 multiplexer.
//   MODE_SELECT / MODE_RR : ARB_MODE encodings (external select / round-robin)
//   sel_width(n)          : width of a channel index, max(1, clog2(n))
package mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Purely combinational round-robin search.
//   req         : per-channel request vector
//   last_grant  : channel granted most recently; the search starts one above it
//   grant       : first requesting channel found, wrapping modulo N
//   grant_valid : high when any channel requests
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last_grant,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  // Walk the channels starting at last_grant+1; the first hit wins and later hits are masked.
  always_comb begin
    int   idx;
    logic hit;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    hit         = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx         = (int'(last_grant) + 1 + i) % N;
      hit         = !grant_valid && req[idx];
      grant       = hit ? SW'(idx) : grant;
      grant_valid = grant_valid | hit;
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data/in_valid      : N input channels, channel k at in_data[k*WIDTH +: WIDTH]
//   in_ready              : one-hot (or zero) ready back to the granted channel
//   sel                   : channel select, used only when ARB_MODE = MODE_SELECT
//   out_data/out_chan     : registered beat and the channel that supplied it
//   out_valid/out_ready   : output handshake
module mux_stream_n
  import mux_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int N        = 4,
  parameter int ARB_MODE = MODE_SELECT,
  localparam int SW      = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SW-1:0]        sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic [SW-1:0]    out_chan_q,   out_chan_d;
  logic             out_valid_q,  out_valid_d;
  logic [SW-1:0]    last_grant_q, last_grant_d;

  logic [WIDTH-1:0] chan_data_s [N];
  logic [SW-1:0]    rr_grant_s;
  logic             rr_valid_s;
  logic [SW-1:0]    grant_s;
  logic             grant_valid_s;
  logic             load_s;
  logic             accept_s;

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign chan_data_s[g] = in_data[g*WIDTH +: WIDTH];
  end

  rr_arbiter_n #(
    .N  (N),
    .SW (SW)
  ) u_rr (
    .req         (in_valid),
    .last_grant  (last_grant_q),
    .grant       (rr_grant_s),
    .grant_valid (rr_valid_s)
  );

  // The output stage can take a new beat when empty or draining this cycle.
  assign load_s = !out_valid_q || out_ready;

  // Grant source: arbiter in round-robin mode, otherwise sel (out-of-range sel grants nothing).
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    if (ARB_MODE == MODE_RR) begin
      grant_s       = rr_grant_s;
      grant_valid_s = rr_valid_s;
    end else begin
      grant_s       = sel;
      grant_valid_s = (int'(sel) < N);
    end
  end

  // Ready only to the granted channel, and only when the output stage can load.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      in_ready[k] = load_s && grant_valid_s && (grant_s == SW'(k));
    end
  end

  // grant_valid_s guards the in_valid lookup so an out-of-range sel never accepts.
  assign accept_s = grant_valid_s && load_s && in_valid[grant_s];

  // Next state of the output stage: load on accept, empty on drain, otherwise hold.
  always_comb begin
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (accept_s) begin
      out_data_d   = chan_data_s[grant_s];
      out_chan_d   = grant_s;
      out_valid_d  = 1'b1;
      last_grant_d = grant_s;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // Output and arbitration state; last_grant resets to N-1 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SW'(N-1);
    end else begin
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed bench for mux_stream_n: select mode (N=4), round-robin mode (N=4)
// and an N=3 select instance for the out-of-range select case.
module tb_mux_stream_n;

  logic clk;
  logic rst_n;

  // select-mode instance, WIDTH 64, N 4
  logic [255:0] a_in_data;
  logic [3:0]   a_in_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_chan;
  logic [63:0]  a_out_data;
  logic         a_out_valid, a_out_ready;

  // round-robin instance, WIDTH 64, N 4
  logic [255:0] r_in_data;
  logic [3:0]   r_in_valid, r_in_ready;
  logic [1:0]   r_sel, r_out_chan;
  logic [63:0]  r_out_data;
  logic         r_out_valid, r_out_ready;

  // select-mode instance, WIDTH 16, N 3
  logic [47:0]  t_in_data;
  logic [2:0]   t_in_valid, t_in_ready;
  logic [1:0]   t_sel, t_out_chan;
  logic [15:0]  t_out_data;
  logic         t_out_valid, t_out_ready;

  int n_cmp;
  int n_err;

  mux_stream_n #(.WIDTH(64), .N(4), .ARB_MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_stream_n #(.WIDTH(64), .N(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(r_in_data), .in_valid(r_in_valid),
    .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data), .out_chan(r_out_chan),
    .out_valid(r_out_valid), .out_ready(r_out_ready)
  );

  mux_stream_n #(.WIDTH(16), .N(3), .ARB_MODE(0)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_data(t_in_data), .in_valid(t_in_valid),
    .in_ready(t_in_ready), .sel(t_sel), .out_data(t_out_data), .out_chan(t_out_chan),
    .out_valid(t_out_valid), .out_ready(t_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_rdy;
    logic [1:0] exp_ch;
    n_cmp = 0;
    n_err = 0;

    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_sel = 2'd0; a_out_ready = 1'b1;
    r_in_data = '0; r_in_valid = '0; r_sel = 2'd0; r_out_ready = 1'b1;
    t_in_data = '0; t_in_valid = '0; t_sel = 2'd0; t_out_ready = 1'b1;
    #12;

    // ---- reset state ----
    chk("rst_data",  64'(a_out_data), 64'h0);
    chk("rst_valid", 64'(a_out_valid), 64'h0);
    chk("rst_chan",  64'(a_out_chan), 64'h0);
    chk("rst_nongrant_ready", 64'(a_in_ready & 4'b1110), 64'h0);
    chk("rst_rr_ready", 64'(r_in_ready), 64'h0);

    rst_n = 1'b1;
    tick();

    // ---- idle for 10 cycles: outputs stay zero ----
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_data",  64'(a_out_data), 64'h0);
      chk("idle_valid", 64'(a_out_valid), 64'h0);
    end

    // ---- select channel 2 ----
    a_sel = 2'd2;
    a_in_data[2*64 +: 64] = 64'hA5A5_0000_0000_0001;
    a_in_valid = 4'b0100;
    #1;
    chk("sel2_ready", 64'(a_in_ready), 64'h4);
    tick();
    chk("sel2_data",  64'(a_out_data), 64'hA5A5_0000_0000_0001);
    chk("sel2_chan",  64'(a_out_chan), 64'h2);
    chk("sel2_valid", 64'(a_out_valid), 64'h1);
    a_in_valid = 4'b0000;
    tick();
    chk("drain_valid", 64'(a_out_valid), 64'h0);
    chk("drain_data_held", 64'(a_out_data), 64'hA5A5_0000_0000_0001);
    chk("drain_chan_held", 64'(a_out_chan), 64'h2);

    // ---- async reset pulse mid-cycle drops a registered beat ----
    a_sel = 2'd1;
    a_in_data[1*64 +: 64] = 64'h0000_0000_0000_1111;
    a_in_valid = 4'b0010;
    tick();
    chk("pre_rst_valid", 64'(a_out_valid), 64'h1);
    a_in_valid = 4'b0000;
    a_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(a_out_valid), 64'h0);
    chk("async_rst_data",  64'(a_out_data), 64'h0);
    chk("async_rst_chan",  64'(a_out_chan), 64'h0);
    #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;

    // ---- stall: frozen outputs, ignored sel changes ----
    a_sel = 2'd1;
    a_in_data[1*64 +: 64] = 64'h0000_0000_0000_1234;
    a_in_valid = 4'b0010;
    tick();
    chk("stall_load_data", 64'(a_out_data), 64'h1234);
    a_out_ready = 1'b0;
    a_in_data[1*64 +: 64] = 64'h0000_0000_0000_5678;
    for (int i = 0; i < 5; i++) begin
      a_sel = 2'(i);
      #1;
      chk("stall_ready", 64'(a_in_ready), 64'h0);
      tick();
      chk("stall_data",  64'(a_out_data), 64'h1234);
      chk("stall_chan",  64'(a_out_chan), 64'h1);
      chk("stall_valid", 64'(a_out_valid), 64'h1);
    end
    a_sel = 2'd1;
    a_out_ready = 1'b1;
    #1;
    chk("unstall_ready", 64'(a_in_ready), 64'h2);
    tick();
    chk("unstall_data",  64'(a_out_data), 64'h5678);
    chk("unstall_chan",  64'(a_out_chan), 64'h1);
    chk("unstall_valid", 64'(a_out_valid), 64'h1);
    a_in_valid = 4'b0000;
    tick();
    chk("unstall_drain", 64'(a_out_valid), 64'h0);

    // ---- round-robin, all channels valid, data = channel index ----
    for (int k = 0; k < 4; k++) r_in_data[k*64 +: 64] = 64'(k);
    r_in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_ch  = 2'(i % 4);
      exp_rdy = 4'b0001 << exp_ch;
      #1;
      chk("rr_ready", 64'(r_in_ready), 64'(exp_rdy));
      tick();
      chk("rr_chan",  64'(r_out_chan), 64'(exp_ch));
      chk("rr_data",  64'(r_out_data), 64'(exp_ch));
      chk("rr_valid", 64'(r_out_valid), 64'h1);
    end

    // ---- sparse round-robin: only ch1 and ch3 valid ----
    r_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      exp_ch  = (i % 2 == 0) ? 2'd1 : 2'd3;
      exp_rdy = 4'b0001 << exp_ch;
      #1;
      chk("rr_sparse_ready_02", 64'(r_in_ready & 4'b0101), 64'h0);
      chk("rr_sparse_ready", 64'(r_in_ready), 64'(exp_rdy));
      tick();
      chk("rr_sparse_chan", 64'(r_out_chan), 64'(exp_ch));
      chk("rr_sparse_data", 64'(r_out_data), 64'(exp_ch));
    end

    // ---- round-robin with nothing valid ----
    r_in_valid = 4'b0000;
    #1;
    chk("rr_none_ready", 64'(r_in_ready), 64'h0);
    tick();
    chk("rr_none_valid", 64'(r_out_valid), 64'h0);

    // ---- N=3, out-of-range select ----
    t_sel = 2'd0;
    t_in_data[0 +: 16] = 16'h00AB;
    t_in_valid = 3'b001;
    #1;
    chk("n3_ready0", 64'(t_in_ready), 64'h1);
    tick();
    chk("n3_valid", 64'(t_out_valid), 64'h1);
    chk("n3_data",  64'(t_out_data), 64'hAB);
    t_out_ready = 1'b0;
    t_sel = 2'd3;
    #1;
    chk("n3_oor_ready_stall", 64'(t_in_ready), 64'h0);
    tick();
    chk("n3_pending_valid", 64'(t_out_valid), 64'h1);
    t_out_ready = 1'b1;
    #1;
    chk("n3_oor_ready", 64'(t_in_ready), 64'h0);
    tick();
    chk("n3_drained_valid", 64'(t_out_valid), 64'h0);
    chk("n3_drained_data",  64'(t_out_data), 64'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
